mul_add_seq: RTL and testbench

//   Sequential shift-add multiply-accumulate: computes a*b + c over WIDTH cycles,
//   one multiplier bit per cycle. It is the inverse of the restoring divider in the

---
 rtl/mul_add_seq.sv | 98 +++++++++
 tb/tb_mul_add_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// Purpose : sequential shift-add multiply-accumulate, product = a*b + c (unsigned).
// Latency : WIDTH+1 cycles from enable sample to the done pulse; one op per WIDTH+2 cycles.
// Backpr. : enable/a/b/c are only sampled while idle (busy=0); requests while busy are dropped.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-low reset
//   enable          start request, sampled only when idle
//   a, b, c         multiplicand, multiplier, addend (unsigned, WIDTH bits)
//   product         registered a*b+c (2*WIDTH bits), held until the next done
//   result          registered low WIDTH bits of product
//   ovf             registered flag: product does not fit in WIDTH bits
//   busy            high while an operation is in progress
//   done            one-cycle pulse when product/result/ovf are updated
module mul_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     result,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        // The addend seeds the accumulator, so c costs no extra cycle.
                        acc    <= {{WIDTH{1'b0}}, c};
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Always runs the full WIDTH steps so latency is data-independent.
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    product <= acc;
                    result  <= acc[WIDTH-1:0];
                    ovf     <= |acc[2*WIDTH-1:WIDTH];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic [W-1:0]    c = '0;
    logic [2*W-1:0]  product;
    logic [W-1:0]    result;
    logic            ovf;
    logic            busy;
    logic            done;

    mul_add_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .a       (a),
        .b       (b),
        .c       (c),
        .product (product),
        .result  (result),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    exp_t sbq[$];

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
        longint unsigned p;
        p = 64'(x) * 64'(y) + 64'(z);
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            check("done_one_cycle", 64'(prev_done), 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: product=%0h with nothing expected (cycle %0d)",
                         product, cyc);
            end else begin
                e = sbq.pop_front();
                check("product", 64'(product), 64'(e.prod));
                check("result", 64'(result), 64'(e.prod[W-1:0]));
                check("ovf", 64'(ovf), 64'(|e.prod[2*W-1:W]));
                check("latency", 64'(cyc), 64'(e.due));
                check("busy_at_done", 64'(busy), 64'd0);
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    // Starts an operation at the next edge and records its expected response.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, input logic [2*W-1:0] want);
        @(negedge clk);
        wait_idle();
        a = x;
        b = y;
        c = z;
        enable = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back('{prod: want, due: cyc + W + 1});
        enable = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        logic [31:0] d;
        logic [31:0] n;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_product", 64'(product), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;

        // Directed basics
        issue(16'd5, 16'd3, 16'd2, 32'h0000_0011);
        drain();
        issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000);
        drain();
        issue(16'd142, 16'd7, 16'd6, 32'd1000);
        drain();

        // Zero multiplier, with input churn and enable pulses while busy
        issue(16'hABCD, 16'h0000, 16'h0042, 32'h0000_0042);
        repeat (10) begin
            @(negedge clk);
            a = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            enable = ~enable;
        end
        enable = 1'b0;
        drain();
        issue(16'h0000, 16'h1234, 16'hFFFF, 32'h0000_FFFF);
        drain();

        // Enable held high: back-to-back ops every W+2 cycles
        @(negedge clk);
        wait_idle();
        a = 16'd2;
        b = 16'd3;
        c = 16'd1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        base = cyc;
        sbq.push_back('{prod: 32'd7, due: cyc + W + 1});
        a = 16'd4;
        b = 16'd4;
        c = 16'd0;
        bad = 0;
        for (int k = 0; k < 2 * (W + 2); k++) begin
            @(negedge clk);
            if (busy !== ((k != W + 1) && (k != 2 * W + 3))) bad++;
            if (k == W + 1) begin
                @(posedge clk);
                #1;
                sbq.push_back('{prod: 32'd16, due: cyc + W + 1});
            end
            if (k == 2 * W + 3) enable = 1'b0;
        end
        enable = 1'b0;
        check("held_busy_pattern", 64'(bad), 64'd0);
        check("held_second_start", 64'(cyc - base), 64'(2 * (W + 2) - 1));
        drain();

        // Reset in the middle of CALC aborts without done
        issue(16'h1234, 16'h5678, 16'h0009, model(16'h1234, 16'h5678, 16'h0009));
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        void'(sbq.pop_back());
        repeat (30) @(negedge clk);
        issue(16'd9, 16'd9, 16'd0, 32'd81);
        drain();

        // Divider round-trip: random dividend/divisor, feed quotient, divisor, remainder
        for (int i = 0; i < 1000; i++) begin
            d = $urandom_range(1, 65535);
            n = $urandom_range(0, d * 32'd65536 - 32'd1);
            x = 16'(n / d);
            y = d[W-1:0];
            z = 16'(n % d);
            issue(x, y, z, n);
        end
        drain();

        // Random full-range operands against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            x = 16'($urandom);
            y = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
            z = 16'($urandom);
            issue(x, y, z, model(x, y, z));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
